// File: rtl/usr_serializer_ctrl.sv
// usr_serializer_ctrl: control stage for an N-bit universal shift register.
// Accepts a word on a valid/ready handshake, loads it into the register, then
// shifts it out one bit per DIV-cycle bit period (MSB- or LSB-first), reading
// the register's q back to drive the serial output.
module usr_serializer_ctrl #(
    parameter int unsigned N        = 8,
    parameter int unsigned DIV      = 4,
    parameter logic        FILL     = 1'b0,
    parameter logic        IDLE_LVL = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_msb_first,
    input  logic         abort,
    output logic [1:0]   sr_ctrl,
    output logic [N-1:0] sr_d,
    input  logic [N-1:0] sr_q,
    output logic         ser_out,
    output logic         bit_strobe,
    output logic         busy,
    output logic         done
);

    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    // Shift register command codes.
    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_SHL  = 2'b01,
        OP_SHR  = 2'b10,
        OP_LOAD = 2'b11
    } sr_op_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             dir_q, dir_d;

    logic handshake;
    logic period_end;
    logic last_bit;

    // Handshake and bit-period boundary decode.
    always_comb begin
        in_ready   = (state_q == S_IDLE) && !abort;
        handshake  = in_valid && in_ready;
        period_end = (div_cnt_q == DIV_LAST);
        last_bit   = (bit_cnt_q == BIT_LAST);
    end

    // Next-state and counter update.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        dir_d     = dir_q;
        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    dir_d     = in_msb_first;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = S_IDLE;
                end else if (period_end) begin
                    div_cnt_d = '0;
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        state_d   = S_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                state_d   = S_IDLE;
            end
            default: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // Output decode from state, counters and the register's read-back.
    always_comb begin
        sr_ctrl    = OP_HOLD;
        sr_d       = '0;
        ser_out    = IDLE_LVL;
        bit_strobe = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    sr_ctrl = OP_LOAD;
                    sr_d    = in_data;
                end
            end
            S_SHIFT: begin
                busy       = 1'b1;
                ser_out    = dir_q ? sr_q[N-1] : sr_q[0];
                bit_strobe = (div_cnt_q == '0);
                sr_d       = {N{FILL}};
                // The final bit is left in place: no shift after the last period.
                if (!abort && period_end && !last_bit)
                    sr_ctrl = dir_q ? OP_SHL : OP_SHR;
            end
            S_DONE: begin
                busy = 1'b1;
                done = !abort;
            end
            default: ;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            dir_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            dir_q     <= dir_d;
        end
    end

endmodule

// File: tb/tb_usr_serializer_ctrl.sv
// Testbench for usr_serializer_ctrl: three instances (DIV=4/FILL=0,
// DIV=4/FILL=1, DIV=1/FILL=0), each closing the loop through a behavioural
// universal shift register.
module tb_usr_serializer_ctrl;

    localparam int unsigned N  = 8;
    localparam int unsigned NI = 3;

    logic clk = 1'b0;
    logic reset;

    logic         in_valid_a   [NI];
    logic         in_ready_a   [NI];
    logic [N-1:0] in_data_a    [NI];
    logic         in_msb_a     [NI];
    logic         abort_a      [NI];
    logic [1:0]   sr_ctrl_a    [NI];
    logic [N-1:0] sr_d_a       [NI];
    logic [N-1:0] sr_q_a       [NI];
    logic         ser_out_a    [NI];
    logic         bit_strobe_a [NI];
    logic         busy_a       [NI];
    logic         done_a       [NI];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        usr_serializer_ctrl #(
            .N        (N),
            .DIV      ((g == 2) ? 1 : 4),
            .FILL     ((g == 1) ? 1'b1 : 1'b0),
            .IDLE_LVL (1'b1)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .in_valid     (in_valid_a[g]),
            .in_ready     (in_ready_a[g]),
            .in_data      (in_data_a[g]),
            .in_msb_first (in_msb_a[g]),
            .abort        (abort_a[g]),
            .sr_ctrl      (sr_ctrl_a[g]),
            .sr_d         (sr_d_a[g]),
            .sr_q         (sr_q_a[g]),
            .ser_out      (ser_out_a[g]),
            .bit_strobe   (bit_strobe_a[g]),
            .busy         (busy_a[g]),
            .done         (done_a[g])
        );
    end

    // Behavioural universal shift register behind each instance.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            case (sr_ctrl_a[i])
                2'b01:   sr_q_a[i] <= {sr_q_a[i][N-2:0], sr_d_a[i][0]};
                2'b10:   sr_q_a[i] <= {sr_d_a[i][N-1], sr_q_a[i][N-1:1]};
                2'b11:   sr_q_a[i] <= sr_d_a[i];
                default: ;
            endcase
        end
    end

    function automatic int div_of(input int i);
        return (i == 2) ? 1 : 4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one word on instance i; collect bits at strobes, final sr_q, done offset.
    task automatic send(input int i, input logic [N-1:0] data, input logic msb,
                        input logic [N-1:0] exp_bits, output logic [N-1:0] bits,
                        output logic [N-1:0] fq, output int done_off, output int bad);
        int  dv;
        int  k;
        logic exp_stb;
        dv       = div_of(i);
        bits     = '0;
        fq       = '0;
        done_off = -1;
        bad      = 0;
        in_valid_a[i] = 1'b1;
        in_data_a[i]  = data;
        in_msb_a[i]   = msb;
        #4;
        check("accept_ready", in_ready_a[i], 1);
        check("load_ctrl", sr_ctrl_a[i], 2'b11);
        check("load_d", sr_d_a[i], data);
        tick();
        in_valid_a[i] = 1'b0;
        in_data_a[i]  = ~data;
        in_msb_a[i]   = ~msb;
        for (int off = 1; off <= N * dv + 5; off++) begin
            #4;
            exp_stb = (off <= N * dv) && (((off - 1) % dv) == 0);
            if (bit_strobe_a[i] !== exp_stb) bad++;
            if (off <= N * dv) begin
                k = (off - 1) / dv;
                if (ser_out_a[i] !== exp_bits[N-1-k]) bad++;
            end
            if (in_ready_a[i] !== 1'b0) bad++;
            if (bit_strobe_a[i]) bits = {bits[N-2:0], ser_out_a[i]};
            if (done_a[i]) begin
                done_off = off;
                fq       = sr_q_a[i];
            end
            tick();
            if (done_off >= 0) break;
        end
    endtask

    typedef struct {
        int         inst;
        logic [N-1:0] data;
        logic       msb;
        logic [N-1:0] bits;     // transmission order, first bit in MSB
        logic [N-1:0] final_q;
    } vec_t;

    vec_t vecs [7];

    // Random-phase reference model state (transaction level).
    logic         m_active;
    int           m_c;
    logic [N-1:0] m_w;
    logic         m_dir;
    logic         e_ready, e_ser, e_stb, e_busy, e_done, hs;
    logic [1:0]   e_ctrl;
    logic [N-1:0] e_d, e_final;
    logic         chk_d;

    logic [N-1:0] bits, fq, q2;
    int           dn, bad, acc, gap;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 8'hA5, 1'b1, 8'b1010_0101, 8'h80};
        vecs[1] = '{0, 8'h1E, 1'b0, 8'b0111_1000, 8'h00};
        vecs[2] = '{1, 8'h1E, 1'b0, 8'b0111_1000, 8'hFE};
        vecs[3] = '{2, 8'h81, 1'b1, 8'b1000_0001, 8'h80};
        vecs[4] = '{0, 8'h3C, 1'b1, 8'b0011_1100, 8'h00};
        vecs[5] = '{0, 8'hC3, 1'b0, 8'b1100_0011, 8'h01};
        vecs[6] = '{1, 8'hA5, 1'b1, 8'b1010_0101, 8'hFF};

        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            in_valid_a[i] = 1'b0;
            in_data_a[i]  = '0;
            in_msb_a[i]   = 1'b0;
            abort_a[i]    = 1'b0;
        end

        // Reset state on every instance.
        tick();
        #4;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_ready%0d", i), in_ready_a[i], 1);
            check($sformatf("rst_ctrl%0d", i), sr_ctrl_a[i], 0);
            check($sformatf("rst_d%0d", i), sr_d_a[i], 0);
            check($sformatf("rst_ser%0d", i), ser_out_a[i], 1);
            check($sformatf("rst_outs%0d", i),
                  {bit_strobe_a[i], busy_a[i], done_a[i]}, 0);
        end
        abort_a[0] = 1'b1;
        #1;
        check("rst_abort_ready", in_ready_a[0], 0);
        abort_a[0] = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // Table of directed words.
        for (int v = 0; v < 7; v++) begin
            send(vecs[v].inst, vecs[v].data, vecs[v].msb, vecs[v].bits, bits, fq, dn, bad);
            check($sformatf("vec%0d_bits", v), bits, vecs[v].bits);
            check($sformatf("vec%0d_final", v), fq, vecs[v].final_q);
            check($sformatf("vec%0d_done_time", v), dn, 1 + N * div_of(vecs[v].inst));
            check($sformatf("vec%0d_timing", v), bad, 0);
        end

        // Back-to-back words with in_valid held high.
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = 8'h3C;
        in_msb_a[0]   = 1'b1;
        #4;
        check("b2b_first_ready", in_ready_a[0], 1);
        tick();
        in_data_a[0] = 8'hC3;
        in_msb_a[0]  = 1'b0;
        acc = -1; dn = -1; gap = 0;
        for (int off = 1; off <= 40; off++) begin
            #4;
            if (done_a[0]) dn = off;
            if ((off == 33 || off == 34) && bit_strobe_a[0]) gap++;
            if (in_ready_a[0]) acc = off;
            tick();
            if (acc >= 0) break;
        end
        in_valid_a[0] = 1'b0;
        check("b2b_first_done", dn, 33);
        check("b2b_second_accept", acc, 34);
        check("b2b_no_strobe_gap", gap, 0);
        #4;
        check("b2b_second_strobe", bit_strobe_a[0], 1);
        check("b2b_second_bit0", ser_out_a[0], 1);
        dn = -1; q2 = '0;
        for (int k = 0; k < 40 && dn < 0; k++) begin
            tick();
            #4;
            if (done_a[0]) begin
                dn = k;
                q2 = sr_q_a[0];
            end
        end
        check("b2b_second_done", dn, 31);
        check("b2b_second_final", q2, 8'h01);
        tick();

        // Abort at the end of bit 3's period.
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = 8'hA5;
        in_msb_a[0]   = 1'b1;
        #4;
        tick();
        in_valid_a[0] = 1'b0;
        for (int off = 1; off < 16; off++) tick();
        abort_a[0] = 1'b1;
        #4;
        check("abort_ctrl", sr_ctrl_a[0], 0);
        check("abort_busy", busy_a[0], 1);
        tick();
        abort_a[0] = 1'b0;
        #4;
        check("abort_idle_ready", in_ready_a[0], 1);
        check("abort_idle_busy", busy_a[0], 0);
        check("abort_sr_frozen", sr_q_a[0], 8'h28);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            #4;
            if (done_a[0] || busy_a[0] || sr_q_a[0] !== 8'h28) bad++;
        end
        check("abort_no_done", bad, 0);
        tick();
        abort_a[0]    = 1'b1;
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = 8'h5A;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            #4;
            if (in_ready_a[0] || sr_ctrl_a[0] !== 2'b00) bad++;
            tick();
        end
        abort_a[0]    = 1'b0;
        in_valid_a[0] = 1'b0;
        #4;
        check("abort_idle_block", bad, 0);
        check("abort_no_accept", busy_a[0], 0);
        tick();

        // Reset asserted mid-SHIFT, then a fresh word.
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = 8'h96;
        in_msb_a[0]   = 1'b1;
        #4;
        tick();
        in_valid_a[0] = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        reset = 1'b1;
        #1;
        check("rstmid_ser", ser_out_a[0], 1);
        check("rstmid_busy", busy_a[0], 0);
        check("rstmid_ctrl", sr_ctrl_a[0], 0);
        check("rstmid_done", done_a[0], 0);
        #3;
        tick();
        reset = 1'b0;
        send(0, 8'h69, 1'b0, 8'b1001_0110, bits, fq, dn, bad);
        check("rstmid_bits", bits, 8'b1001_0110);
        check("rstmid_final", fq, 8'h00);
        check("rstmid_done_time", dn, 33);
        check("rstmid_timing", bad, 0);

        // Randomized traffic on instance 0 against a transaction-level model.
        m_active = 1'b0; m_c = 0; m_w = '0; m_dir = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid_a[0] = 1'($urandom_range(0, 1));
            in_data_a[0]  = N'($urandom);
            in_msb_a[0]   = 1'($urandom_range(0, 1));
            abort_a[0]    = ($urandom_range(0, 49) == 0);
            #4;
            chk_d   = 1'b1;
            e_final = '0;
            hs      = 1'b0;
            if (!m_active) begin
                e_ready = !abort_a[0];
                hs      = in_valid_a[0] && e_ready;
                e_ctrl  = hs ? 2'b11 : 2'b00;
                e_d     = hs ? in_data_a[0] : '0;
                e_ser   = 1'b1;
                e_stb   = 1'b0;
                e_busy  = 1'b0;
                e_done  = 1'b0;
            end else begin
                e_ready = 1'b0;
                e_busy  = 1'b1;
                if (m_c <= N * 4) begin
                    e_ser  = m_dir ? m_w[N-1-(m_c-1)/4] : m_w[(m_c-1)/4];
                    e_stb  = ((m_c - 1) % 4) == 0;
                    e_ctrl = (!abort_a[0] && (m_c % 4) == 0 && (m_c / 4) < N)
                             ? (m_dir ? 2'b01 : 2'b10) : 2'b00;
                    e_d    = '0;
                    e_done = 1'b0;
                end else begin
                    e_ser  = 1'b1;
                    e_stb  = 1'b0;
                    e_ctrl = 2'b00;
                    e_d    = '0;
                    e_done = !abort_a[0];
                    chk_d  = 1'b0;
                end
            end
            check("rand_outs",
                  {in_ready_a[0], sr_ctrl_a[0], ser_out_a[0], bit_strobe_a[0], busy_a[0], done_a[0]},
                  {e_ready, e_ctrl, e_ser, e_stb, e_busy, e_done});
            if (chk_d) check("rand_sr_d", sr_d_a[0], e_d);
            if (e_done) begin
                e_final = m_dir ? (m_w << (N - 1)) : (m_w >> (N - 1));
                check("rand_final", sr_q_a[0], e_final);
            end
            if (m_active) begin
                if (abort_a[0] || m_c == N * 4 + 1) m_active = 1'b0;
                else m_c++;
            end else if (hs) begin
                m_active = 1'b1;
                m_c      = 1;
                m_w      = in_data_a[0];
                m_dir    = in_msb_a[0];
            end
            tick();
        end
        in_valid_a[0] = 1'b0;
        abort_a[0]    = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
